// File: rtl/secondary_road_sensor_conditioner_pkg.sv
// Shared constants for the secondary-road detector conditioner.
// Holds the request FSM encodings, default timing and the request-output decode.
package secondary_road_sensor_conditioner_pkg;

    typedef logic [1:0] ssm_state_t;

    localparam ssm_state_t SENSOR_SSM_IDLE      = 2'h0;
    localparam ssm_state_t SENSOR_SSM_REQUESTED = 2'h1;
    localparam ssm_state_t SENSOR_SSM_SERVING   = 2'h2;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 10000;
    localparam int DEFAULT_STUCK_CYCLES    = 600000000;

    // A waiting vehicle keeps the request up while being served, extending the green.
    function automatic logic request_from_state(input ssm_state_t state, input logic stable);
        return (state == SENSOR_SSM_REQUESTED) || ((state == SENSOR_SSM_SERVING) && stable);
    endfunction

endpackage

// File: rtl/secondary_road_sensor_conditioner_if.sv
// Detector/controller signal bundle. master drives the raw detector and green
// feedback; slave is the conditioner that returns the cleaned request and fault.
interface secondary_road_sensor_conditioner_if;
    logic sensorRaw;
    logic secondaryGreen;
    logic sensorStable;
    logic secondaryRoadSensor;
    logic sensorFault;

    modport master (
        output sensorRaw,
        output secondaryGreen,
        input  sensorStable,
        input  secondaryRoadSensor,
        input  sensorFault
    );

    modport slave (
        input  sensorRaw,
        input  secondaryGreen,
        output sensorStable,
        output secondaryRoadSensor,
        output sensorFault
    );
endinterface

// File: rtl/secondary_road_sensor_conditioner_debouncer.sv
// Two-flop synchroniser followed by a debounce counter: the synchronised level
// must differ from the stable value for DEBOUNCE_CYCLES consecutive edges.
module sensor_debouncer
    import secondary_road_sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             out_q;
    logic             out_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;

    // Any edge where the synchronised level agrees with the stable value restarts the count.
    always_comb begin
        out_d    = out_q;
        db_cnt_d = '0;
        if (s2_q != out_q) begin
            if (db_cnt_q == CNT_LAST) begin
                out_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            out_q    <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            s1_q     <= in;
            s2_q     <= s1_q;
            out_q    <= out_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/secondary_road_sensor_conditioner.sv
// Turns the raw secondary-road detector into a latched vehicle request for the
// traffic light controller, plus a sticky fault for a detector stuck occupied.
module secondary_road_sensor_conditioner
    import secondary_road_sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
    input logic                                clk,
    input logic                                reset,
    secondary_road_sensor_conditioner_if.slave bus
);

    localparam int               ST_W    = $clog2(STUCK_CYCLES + 1);
    localparam logic [ST_W-1:0]  ST_LAST = ST_W'(STUCK_CYCLES - 1);

    logic            stable;
    ssm_state_t      state_q;
    ssm_state_t      state_d;
    logic [ST_W-1:0] stuck_cnt_q;
    logic [ST_W-1:0] stuck_cnt_d;
    logic            fault_q;
    logic            fault_d;
    logic            req_q;
    logic            req_d;

    sensor_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk  (clk),
        .reset(reset),
        .in   (bus.sensorRaw),
        .out  (stable)
    );

    // The stuck counter saturates one short of the limit once the fault is declared.
    always_comb begin
        stuck_cnt_d = stuck_cnt_q;
        fault_d     = fault_q;
        if (!stable) begin
            stuck_cnt_d = '0;
        end else if (stuck_cnt_q == ST_LAST) begin
            fault_d = 1'b1;
        end else begin
            stuck_cnt_d = stuck_cnt_q + 1'b1;
        end
    end

    // Level-sensitive entry from IDLE; a request is held until served even if the vehicle leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SENSOR_SSM_IDLE: begin
                if (stable) begin
                    state_d = bus.secondaryGreen ? SENSOR_SSM_SERVING : SENSOR_SSM_REQUESTED;
                end
            end
            SENSOR_SSM_REQUESTED: begin
                if (bus.secondaryGreen) begin
                    state_d = SENSOR_SSM_SERVING;
                end
            end
            SENSOR_SSM_SERVING: begin
                if (!bus.secondaryGreen) begin
                    state_d = stable ? SENSOR_SSM_REQUESTED : SENSOR_SSM_IDLE;
                end
            end
            default: state_d = SENSOR_SSM_IDLE;
        endcase
        if (fault_d) begin
            state_d = SENSOR_SSM_IDLE;
        end
        req_d = fault_d ? 1'b0 : request_from_state(state_d, stable);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SENSOR_SSM_IDLE;
            stuck_cnt_q <= '0;
            fault_q     <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stuck_cnt_q <= stuck_cnt_d;
            fault_q     <= fault_d;
            req_q       <= req_d;
        end
    end

    assign bus.sensorStable        = stable;
    assign bus.secondaryRoadSensor = req_q;
    assign bus.sensorFault         = fault_q;

endmodule

// File: tb/tb_secondary_road_sensor_conditioner.sv
// Directed bench for the secondary-road detector conditioner with short timing
// (debounce 4, stuck 20); edge numbers count from the last reset edge as 0.
module tb_secondary_road_sensor_conditioner;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    secondary_road_sensor_conditioner_if bus ();

    secondary_road_sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .STUCK_CYCLES   (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Holds reset for n edges; the last of them is edge 0 for the scenario.
    task automatic do_reset(input int n, input logic raw);
        reset              = 1'b1;
        bus.sensorRaw      = raw;
        bus.secondaryGreen = 1'b0;
        ticks(n);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp              = 0;
        n_err              = 0;
        reset              = 1'b1;
        bus.sensorRaw      = 1'b0;
        bus.secondaryGreen = 1'b0;

        // 1: vehicle present through reset, request raised after release
        reset         = 1'b1;
        bus.sensorRaw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_stable", bus.sensorStable, 1'b0);
            check("rst_req", bus.secondaryRoadSensor, 1'b0);
            check("rst_fault", bus.sensorFault, 1'b0);
        end
        reset = 1'b0;
        ticks(5);
        check("s1_stable_e5", bus.sensorStable, 1'b0);
        tick();
        check("s1_stable_e6", bus.sensorStable, 1'b1);
        check("s1_req_e6", bus.secondaryRoadSensor, 1'b0);
        tick();
        check("s1_req_e7", bus.secondaryRoadSensor, 1'b1);

        // 2: 3-cycle glitch is discarded
        do_reset(2, 1'b0);
        bus.sensorRaw = 1'b1;
        ticks(3);
        bus.sensorRaw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s2_stable", bus.sensorStable, 1'b0);
            check("s2_req", bus.secondaryRoadSensor, 1'b0);
        end

        // 3: vehicle leaves before green, request held until served once
        do_reset(2, 1'b1);
        ticks(7);
        check("s3_req_e7", bus.secondaryRoadSensor, 1'b1);
        bus.sensorRaw = 1'b0;
        ticks(10);
        check("s3_stable_gone", bus.sensorStable, 1'b0);
        check("s3_req_held", bus.secondaryRoadSensor, 1'b1);
        bus.secondaryGreen = 1'b1;
        tick();
        check("s3_req_served", bus.secondaryRoadSensor, 1'b0);
        tick();
        check("s3_req_green", bus.secondaryRoadSensor, 1'b0);
        bus.secondaryGreen = 1'b0;
        tick();
        check("s3_req_idle", bus.secondaryRoadSensor, 1'b0);
        ticks(3);
        check("s3_req_idle_hold", bus.secondaryRoadSensor, 1'b0);

        // 4: vehicle stays through green, extends it and re-requests
        do_reset(2, 1'b1);
        ticks(7);
        check("s4_req_e7", bus.secondaryRoadSensor, 1'b1);
        bus.secondaryGreen = 1'b1;
        tick();
        check("s4_req_serving", bus.secondaryRoadSensor, 1'b1);
        tick();
        check("s4_req_serving2", bus.secondaryRoadSensor, 1'b1);
        bus.secondaryGreen = 1'b0;
        tick();
        check("s4_req_rerequest", bus.secondaryRoadSensor, 1'b1);
        tick();
        check("s4_req_requested", bus.secondaryRoadSensor, 1'b1);
        check("s4_fault", bus.sensorFault, 1'b0);

        // 5: stuck detector raises sticky fault 20 edges after stable rises
        do_reset(2, 1'b1);
        ticks(25);
        check("s5_fault_e25", bus.sensorFault, 1'b0);
        check("s5_req_e25", bus.secondaryRoadSensor, 1'b1);
        tick();
        check("s5_fault_e26", bus.sensorFault, 1'b1);
        check("s5_req_e26", bus.secondaryRoadSensor, 1'b0);
        check("s5_stable_e26", bus.sensorStable, 1'b1);
        bus.sensorRaw = 1'b0;
        ticks(10);
        check("s5_fault_sticky", bus.sensorFault, 1'b1);
        check("s5_stable_drop", bus.sensorStable, 1'b0);
        check("s5_req_forced", bus.secondaryRoadSensor, 1'b0);
        reset = 1'b1;
        tick();
        check("s5_fault_cleared", bus.sensorFault, 1'b0);
        reset = 1'b0;

        // 6: reset mid-debounce and mid-SERVING, then debounce restarts
        do_reset(2, 1'b1);
        ticks(7);
        bus.secondaryGreen = 1'b1;
        tick();
        check("s6_req_serving", bus.secondaryRoadSensor, 1'b1);
        bus.sensorRaw = 1'b0;
        ticks(4);
        check("s6_stable_pre", bus.sensorStable, 1'b1);
        reset = 1'b1;
        tick();
        check("s6_rst_stable", bus.sensorStable, 1'b0);
        check("s6_rst_req", bus.secondaryRoadSensor, 1'b0);
        check("s6_rst_fault", bus.sensorFault, 1'b0);
        reset              = 1'b0;
        bus.sensorRaw      = 1'b1;
        bus.secondaryGreen = 1'b0;
        ticks(5);
        check("s6_stable_e5", bus.sensorStable, 1'b0);
        tick();
        check("s6_stable_e6", bus.sensorStable, 1'b1);
        tick();
        check("s6_req_e7", bus.secondaryRoadSensor, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
